// File: rtl/ram_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_if
// Brief    : Access bus for the single-port RAM (write enable, address, data).
// Revision : 1.0 - initial release
// ============================================================================
interface ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output we,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  we,
    input  addr,
    input  data_in,
    output data_out
  );
endinterface : ram_if
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// ============================================================================
// Module   : ram
// Brief    : Single-port synchronous RAM, registered write-first read port,
//            asynchronous clear of array and output register.
// Revision : 1.0 - initial release
// ============================================================================
module ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  wire logic clk,
  input  wire logic rst_n,
  ram_if.slave      bus
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;

  // Array is built from plain flops so the whole store can be cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_data_out <= '0;
    end else begin
      if (bus.we) begin
        r_mem[bus.addr] <= bus.data_in;
        r_data_out      <= bus.data_in;
      end else begin
        r_data_out      <= r_mem[bus.addr];
      end
    end
  end

  assign bus.data_out = r_data_out;

endmodule : ram
`default_nettype wire

// File: tb/tb_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram
// Brief    : Directed scoreboard testbench for the single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram;

  localparam int c_DW    = 8;
  localparam int c_AW    = 3;
  localparam int c_DEPTH = 2 ** c_AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ram_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus ();

  ram #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [c_DW-1:0] model [c_DEPTH];
  logic [c_DW-1:0] sb_q [$];
  logic [c_DW-1:0] last_exp;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic check(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < c_DEPTH; i++) model[i] = '0;
    sb_q.delete();
  endtask

  // One access per clock; expectation queued at drive time, checked 1 cycle later.
  task automatic access(input string tag, input logic w, input logic [c_AW-1:0] a,
                        input logic [c_DW-1:0] d);
    logic [c_DW-1:0] exp;
    bus.we      = w;
    bus.addr    = a;
    bus.data_in = d;
    if (w) begin
      sb_q.push_back(d);
      model[a] = d;
    end else begin
      sb_q.push_back(model[a]);
    end
    @(posedge clk);
    #1;
    exp      = sb_q.pop_front();
    last_exp = exp;
    check(tag, bus.data_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    model_clear();

    #12;
    check("reset_out", bus.data_out, 8'h00);
    rst_n = 1'b1;

    for (int k = 0; k < c_DEPTH; k++) access("post_reset_read", 1'b0, c_AW'(k), 8'h00);

    access("wr0",     1'b1, 3'd0, 8'hA5);
    access("rd0",     1'b0, 3'd0, 8'h00);
    access("wr1",     1'b1, 3'd1, 8'h3C);
    access("rd1",     1'b0, 3'd1, 8'h00);
    access("rd0_kept", 1'b0, 3'd0, 8'h00);

    access("wfirst2", 1'b1, 3'd2, 8'h5A);
    access("rd2",     1'b0, 3'd2, 8'h00);

    for (int k = 0; k < c_DEPTH; k++) access("sweep_wr", 1'b1, c_AW'(k), 8'h10 + 8'(k));
    for (int k = c_DEPTH - 1; k >= 0; k--) access("sweep_rd", 1'b0, c_AW'(k), 8'h00);

    access("ovw7",    1'b1, 3'd7, 8'hFF);
    access("rd6",     1'b0, 3'd6, 8'h00);
    access("rd7",     1'b0, 3'd7, 8'h00);

    // Address changes between edges must not disturb the registered output.
    #2;
    bus.addr = 3'd3;
    #2;
    check("hold_addr_change", bus.data_out, last_exp);
    bus.addr = 3'd5;
    #2;
    check("hold_addr_change2", bus.data_out, last_exp);
    @(posedge clk);
    #1;
    check("hold_then_update", bus.data_out, 8'h15);

    // Asynchronous reset between edges, held across an edge with a write pending.
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_out", bus.data_out, 8'h00);
    model_clear();
    bus.we      = 1'b1;
    bus.addr    = 3'd4;
    bus.data_in = 8'h77;
    @(posedge clk);
    #1;
    check("reset_ignores_write", bus.data_out, 8'h00);
    #2;
    rst_n = 1'b1;

    for (int k = 0; k < c_DEPTH; k++) access("post_mid_reset_read", 1'b0, c_AW'(k), 8'h00);

    access("final_wr", 1'b1, 3'd4, 8'hC3);
    access("final_rd", 1'b0, 3'd4, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram
`default_nettype wire
